lsu_mem_interface: RTL
======================

Name: lsu_mem_interface

Overview:
Multi-cycle load/store unit that consumes the 3-bit memory Mode produced by the memory control decode and performs the access on a word-wide req/ack data-memory bus. It generates byte enables and store-lane replication, sign/zero-extends load data, and stalls the core while the access is outstanding. It also detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, REQ-state cycles without MemAck before abort; 0 disables the timeout
ADDR_W, 32, byte address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemEn  in  1  current instruction accesses memory
Mode  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
Addr  in  ADDR_W  byte address from ALU
WriteData  in  32  store source (rs2)
Stall  out  1  hold PC/pipeline this cycle
Done  out  1  one-cycle pulse: access complete, ReadData valid
ReadData  out  32  extended load result, held until next Done
MisalignFault  out  1  misaligned access rejected (combinational, IDLE only)
BusError  out  1  with Done: access aborted by timeout
MemReq  out  1  bus request (registered)
MemWE  out  1  1 = write
MemAddr  out  ADDR_W  word-aligned address {Addr[ADDR_W-1:2],2'b00}
MemBE  out  4  byte enables
MemWData  out  32  lane-replicated store data
MemRData  in  32  read data, valid with MemAck
MemAck  in  1  bus completes request this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE, MemReq/MemWE/Done/BusError=0, MemAddr/MemBE/MemWData/ReadData=0, timeout counter=0. Reset during REQ drops MemReq immediately; the access is abandoned.
- States: IDLE, REQ, DONE.
- Misaligned: LH/LHU/SH with Addr[0]=1; LW/SW with Addr[1:0]!=0. Byte accesses are never misaligned.
- IDLE, MemEn=0: Stall=0, no action.
- IDLE, MemEn=1, misaligned: MisalignFault=1, Stall=0, no bus request, stay IDLE.
- IDLE, MemEn=1, aligned: Stall=1. At the edge, register Mode/Addr[1:0], MemAddr, MemBE, MemWData and MemWE (=Mode[2]&(Mode!=100)), set MemReq=1, move to REQ, clear counter.
- MemBE: loads 1111. SB: 0001<<Addr[1:0]. SH: Addr[1] ? 1100 : 0011. SW: 1111.
- MemWData: SB {4{WriteData[7:0]}}, SH {2{WriteData[15:0]}}, SW WriteData. Loads drive 0.
- REQ: Stall=1. MemReq, MemAddr, MemBE, MemWData and MemWE are held stable until the exit edge. The counter increments each cycle.
  - MemAck=1: for a load, latch the formatted MemRData into ReadData. Drop MemReq and go to DONE with BusError=0.
  - No ack and counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0): drop MemReq, ReadData=0, BusError=1, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: Done=1, Stall=0, so the core retires the instruction at this edge. MemEn is ignored. Return to IDLE unconditionally; BusError clears on leaving DONE.
- Load formatting, with lane selected by the latched Addr[1:0]:
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half selected by Addr[1]. LHU: zero-extend that half.
  - LW: full word.
- Stores leave ReadData unchanged.
- Minimum latency: 3 cycles per access (IDLE issue, REQ with ack, DONE).

Decomposition:
- Package lsu_pkg holds:
  - mem_mode_t enum (LB=3'b000 … SW=3'b111, matching the control decode encoding).
  - lsu_state_t {IDLE, REQ, DONE}.
  - Function is_store(mode).
  - Function misaligned(mode, addr[1:0]).
- Sub-module lsu_load_align: combinational MemRData + Mode + Addr[1:0] -> 32-bit extended result; reused by any future pipelined LSU.

Test Plan:
- LW at 0x100, MemAck in the 1st REQ cycle with MemRData=0xDEADBEEF -> MemBE=1111, MemWE=0, Done on cycle 3, ReadData=0xDEADBEEF, Stall high for 2 cycles.
- LB at 0x103, MemRData=0x80_00_00_00 -> ReadData=0xFFFFFF80. Same access as LBU -> 0x00000080. LHU at 0x102 with MemRData=0xBEEF1234 -> 0x0000BEEF.
- SB at 0x201 with WriteData=0x000000A5 -> MemBE=0010, MemWData=0xA5A5A5A5, MemWE=1, MemAddr=0x200. SH at 0x202 -> MemBE=1100.
- LW at 0x102 -> MisalignFault=1 for that cycle, MemReq never asserts, Stall=0.
- TIMEOUT_CYCLES=4, no ack -> MemReq drops after 4 REQ cycles, Done=1 with BusError=1 and ReadData=0. Ack arriving on the 4th cycle -> normal completion, BusError=0.
- rst_n pulsed low in REQ -> MemReq and Stall go 0 without waiting for a clock. After release, state is IDLE and the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: memory mode encoding,
// FSM states, and the store-side lane/alignment functions.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b011,
        LHU = 3'b100,
        SB  = 3'b101,
        SH  = 3'b110,
        SW  = 3'b111
    } mem_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_store(input mem_mode_t mode);
        return mode[2] && (mode != LHU);
    endfunction

    function automatic logic misaligned(input mem_mode_t mode, input logic [1:0] lo);
        case (mode)
            LH, LHU, SH: return lo[0];
            LW, SW:      return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input mem_mode_t mode, input logic [1:0] lo);
        case (mode)
            SB:      return 4'(4'b0001 << lo);
            SH:      return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input mem_mode_t mode, input logic [31:0] wd);
        case (mode)
            SB:      return {4{wd[7:0]}};
            SH:      return {2{wd[15:0]}};
            SW:      return wd;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  mem_mode_t   mode,
    input  logic [1:0]  lo,
    output logic [31:0] result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'd0;
        case (lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'd0;
        endcase
        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result_c = rdata;
        case (mode)
            LB:      result_c = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_c = {24'd0, byte_sel};
            LH:      result_c = {{16{half_sel[15]}}, half_sel};
            LHU:     result_c = {16'd0, half_sel};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_interface.sv
// Multi-cycle load/store unit driving a word-wide req/ack data-memory bus,
// with misalignment rejection and a request timeout.
module lsu_mem_interface
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemEn,
    input  logic [2:0]        Mode,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic              Stall,
    output logic              Done,
    output logic [31:0]       ReadData,
    output logic              MisalignFault,
    output logic              BusError,
    output logic              MemReq,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [3:0]        MemBE,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData,
    input  logic              MemAck
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t  state, state_next;
    mem_mode_t   mode_in, mode_q;
    logic [1:0]  lo_q;
    logic [CNT_W-1:0] cnt;
    logic        miss, issue, timeout_hit;
    logic [31:0] load_c;

    assign mode_in     = mem_mode_t'(Mode);
    assign miss        = misaligned(mode_in, Addr[1:0]);
    assign issue       = (state == IDLE) && MemEn && !miss;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_load_align u_align (
        .rdata    (MemRData),
        .mode     (mode_q),
        .lo       (lo_q),
        .result_c (load_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; ack takes priority over timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (MemAck || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Core-facing handshake; Stall is forced low while reset is asserted
    always_comb begin
        Stall         = 1'b0;
        Done          = 1'b0;
        MisalignFault = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    MisalignFault = MemEn && miss;
                    Stall         = MemEn && !miss;
                end
                REQ:     Stall = 1'b1;
                DONE:    Done  = 1'b1;
                default: ;
            endcase
        end
    end

    // Bus request, timeout counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemReq   <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemBE    <= 4'd0;
            MemWData <= 32'd0;
            ReadData <= 32'd0;
            BusError <= 1'b0;
            mode_q   <= LB;
            lo_q     <= 2'd0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    MemReq   <= 1'b1;
                    MemWE    <= is_store(mode_in);
                    MemAddr  <= {Addr[ADDR_W-1:2], 2'b00};
                    MemBE    <= store_be(mode_in, Addr[1:0]);
                    MemWData <= store_data(mode_in, WriteData);
                    mode_q   <= mode_in;
                    lo_q     <= Addr[1:0];
                    cnt      <= '0;
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (MemAck) begin
                        MemReq   <= 1'b0;
                        MemWE    <= 1'b0;
                        BusError <= 1'b0;
                        if (!is_store(mode_q)) ReadData <= load_c;
                    end else if (timeout_hit) begin
                        MemReq   <= 1'b0;
                        MemWE    <= 1'b0;
                        BusError <= 1'b1;
                        ReadData <= 32'd0;
                    end
                end
                DONE:    BusError <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
